ps2_operation_encoder: RTL and testbench

- Keyboard front end that drives the `operation[4:0]` input of `main`; it is the producer side of that command interface.
- Receives PS/2 frames from the keyboard, decodes scan codes and emits one-cycle, one-hot `operation` pulses: the same pulse shape `main` consumes for move / confirm.
- Sits between the board PS/2 pins and `main`; all logic runs on `clk_100mhz`.

---
 rtl/ps2_operation_encoder_if.sv | 22 ++
 rtl/ps2_operation_encoder.sv | 194 +++++++++++++++++++
 tb/tb_ps2_operation_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_operation_encoder_if.sv
// ----------------------------------------------------------------------------
// ps2_operation_encoder_if
// Bundles the keyboard-side PS/2 lines and the command outputs of the
// ps2_operation_encoder.
//   ps2_clk    raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data   raw PS/2 data from the keyboard (asynchronous)
//   operation  one-cycle one-hot command pulse: [0]=up [1]=down [2]=left
//              [3]=right [4]=enter, 0 = no command
//   frame_err  one-cycle pulse on a framing or parity error
// Modports: master = keyboard / command consumer side, slave = encoder.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ps2_operation_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] operation;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data, input operation, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output operation, output frame_err);
endinterface

// File: rtl/ps2_operation_encoder.sv
// ----------------------------------------------------------------------------
// ps2_operation_encoder
// Receives PS/2 keyboard frames, decodes scan codes (with E0 / F0 prefixes)
// and emits one-cycle one-hot operation pulses for the game core.
// Ports:
//   clk_100mhz  system clock
//   rst         synchronous active-low reset
//   bus         ps2_operation_encoder_if.slave (ps2_clk, ps2_data in;
//               operation, frame_err out)
// Parameters:
//   SYNC_STAGES     synchroniser depth for ps2_clk / ps2_data (>= 2)
//   TIMEOUT_CYCLES  idle clocks in RECV before a partial frame is dropped (>= 2)
// Optional feature:
//   OP_REPEAT_EN    when defined, typematic repeat make codes of a held key
//                   pulse the operation again; otherwise one pulse per press.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_operation_encoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk_100mhz,
  input  logic                        rst,
  ps2_operation_encoder_if.slave      bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

`ifdef OP_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RECV, DECODE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [10:0]            shift_q, shift_d;
  logic                   e0_q, e0_d;
  logic                   f0_q, f0_d;
  logic [4:0]             held_q, held_d;
  logic [TW-1:0]          timeout_q, timeout_d;
  logic [4:0]             operation_q, operation_d;
  logic                   frame_err_q, frame_err_d;

  logic       ps2_clk_s, ps2_data_s, fall;
  logic       frame_valid;
  logic [7:0] code;
  logic       key_hit;
  logic [2:0] key_idx;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  // Shift register fills LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign code        = shift_q[8:1];
  assign frame_valid = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

  // Arrow keys (E0-prefixed) share a slot with their WASD equivalents.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case ({e0_q, code})
      9'h01D, 9'h175: key_idx = 3'd0;
      9'h01B, 9'h172: key_idx = 3'd1;
      9'h01C, 9'h16B: key_idx = 3'd2;
      9'h023, 9'h174: key_idx = 3'd3;
      9'h05A, 9'h15A: key_idx = 3'd4;
      default:        key_hit = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
    clk_prev_d  = ps2_clk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    e0_d        = e0_q;
    f0_d        = f0_q;
    held_d      = held_q;
    timeout_d   = timeout_q;
    operation_d = '0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          shift_d   = {ps2_data_s, shift_q[10:1]};
          bit_cnt_d = 4'd1;
          timeout_d = '0;
          state_d   = RECV;
        end
      end

      RECV: begin
        if (fall) begin
          shift_d   = {ps2_data_s, shift_q[10:1]};
          timeout_d = '0;
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            state_d   = DECODE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Stalled partial frame: drop it silently.
          bit_cnt_d = 4'd0;
          timeout_d = '0;
          state_d   = IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      DECODE: begin
        state_d = IDLE;
        if (!frame_valid) begin
          frame_err_d = 1'b1;
          e0_d        = 1'b0;
          f0_d        = 1'b0;
        end else if (code == 8'hE0) begin
          e0_d = 1'b1;
        end else if (code == 8'hF0) begin
          f0_d = 1'b1;
        end else begin
          e0_d = 1'b0;
          f0_d = 1'b0;
          if (key_hit) begin
            if (f0_q) begin
              held_d[key_idx] = 1'b0;
            end else if (!held_q[key_idx] || REPEAT_EN) begin
              held_d[key_idx]      = 1'b1;
              operation_d[key_idx] = 1'b1;
            end
          end
        end
        // An edge landing in the decode cycle is bit 0 of the next frame.
        if (fall) begin
          shift_d   = {ps2_data_s, shift_q[10:1]};
          bit_cnt_d = 4'd1;
          timeout_d = '0;
          state_d   = RECV;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      e0_q        <= 1'b0;
      f0_q        <= 1'b0;
      held_q      <= '0;
      timeout_q   <= '0;
      operation_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      e0_q        <= e0_d;
      f0_q        <= f0_d;
      held_q      <= held_d;
      timeout_q   <= timeout_d;
      operation_q <= operation_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.operation = operation_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_operation_encoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_operation_encoder
// Drives PS/2 frames into ps2_operation_encoder from a table of scan codes,
// plus hand-written timeout and mid-frame reset sequences. Expected pulses
// (value and arrival cycle) are queued when each stop edge is driven and
// compared by a monitor whenever the encoder produces an output.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_operation_encoder;

  localparam int H       = 10;    // PS/2 half bit period in system clocks
  localparam int TIMEOUT = 1000;  // scaled-down receive timeout

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    logic [4:0] op;
    bit         err;
  } vec_t;

  typedef struct {
    logic [4:0] op;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  ps2_operation_encoder_if bus ();

  ps2_operation_encoder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_100mhz(clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every nonzero output must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    if (rst === 1'b1 && (bus.operation !== 5'd0 || bus.frame_err !== 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {26'd0, bus.frame_err, bus.operation}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("operation", {27'd0, bus.operation}, {27'd0, e.op});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.err});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Sends the first n bits of a frame; the expectation for a complete frame
  // is queued right before its 11th falling edge is driven.
  task automatic send_bits(input logic [10:0] bits, input int n,
                           input logic [4:0] eop, input logic eerr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = bits[i];
      repeat (H) @(negedge clk);
      if (i == 10 && (eop != 5'd0 || eerr)) sb.push_back('{eop, eerr, cyc + 4});
      bus.ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input logic [4:0] eop, input logic eerr);
    send_bits(make_frame(b, bad_par), 11, eop, eerr);
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rep_up, rep_enter;
`ifdef OP_REPEAT_EN
    rep_up    = 5'b00001;
    rep_enter = 5'b10000;
`else
    rep_up    = 5'b00000;
    rep_enter = 5'b00000;
`endif

    vecs.push_back('{8'h1D, 1'b0, 5'b00001, 1'b0});   // W make
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});   // up arrow while W held
    vecs.push_back('{8'h75, 1'b0, rep_up,   1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});   // W break
    vecs.push_back('{8'h1D, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});   // break of key not held
    vecs.push_back('{8'h1D, 1'b0, 5'b00000, 1'b0});
    for (int k = 0; k < 4; k++) begin                 // right arrow press/release x4
      vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});
      vecs.push_back('{8'h74, 1'b0, 5'b01000, 1'b0});
      vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});
      vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
      vecs.push_back('{8'h74, 1'b0, 5'b00000, 1'b0});
    end
    vecs.push_back('{8'h5A, 1'b0, 5'b10000, 1'b0});   // enter, then typematic repeat
    vecs.push_back('{8'h5A, 1'b0, rep_enter, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h5A, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h23, 1'b1, 5'b00000, 1'b1});   // D with bad parity
    vecs.push_back('{8'h23, 1'b0, 5'b01000, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h23, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});   // bad frame clears E0
    vecs.push_back('{8'h74, 1'b1, 5'b00000, 1'b1});
    vecs.push_back('{8'h74, 1'b0, 5'b00000, 1'b0});   // plain 0x74 is unmapped
    vecs.push_back('{8'h15, 1'b0, 5'b00000, 1'b0});   // unmapped code
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});   // left arrow
    vecs.push_back('{8'h6B, 1'b0, 5'b00100, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h6B, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});   // keypad enter
    vecs.push_back('{8'h5A, 1'b0, 5'b10000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h5A, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h1B, 1'b0, 5'b00010, 1'b0});   // S
    vecs.push_back('{8'hF0, 1'b0, 5'b00000, 1'b0});
    vecs.push_back('{8'h1B, 1'b0, 5'b00000, 1'b0});

    // Reset state.
    rst          = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_operation", {27'd0, bus.operation}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].op, vecs[i].err);

    // Partial frame abandoned by the keyboard, then a full A frame.
    send_bits(make_frame(8'h1C, 1'b0), 5, 5'b00000, 1'b0);
    repeat (TIMEOUT + TIMEOUT / 2) @(negedge clk);
    send_frame(8'h1C, 1'b0, 5'b00100, 1'b0);
    send_frame(8'hF0, 1'b0, 5'b00000, 1'b0);
    send_frame(8'h1C, 1'b0, 5'b00000, 1'b0);

    // Reset asserted for 3 clocks in the middle of a frame.
    send_bits(make_frame(8'h1D, 1'b0), 5, 5'b00000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_operation", {27'd0, bus.operation}, 32'd0);
      check("midreset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h1B, 1'b0, 5'b00010, 1'b0);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
